// File: rtl/tff_toggle_arbiter.sv
// tff_toggle_arbiter: round-robin sequencer in front of a bank of toggle flip-flops.
// A granted request toggles one bank bit once per unpaused clock for its requested count.
module tff_toggle_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*IDX_W-1:0]   req_idx,
  input  logic [N_REQ*CNT_W-1:0]   req_cnt,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     pause,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]         done,
  output logic                     err
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int CW    = GID_W + 1;

  typedef enum logic {IDLE, TOGGLE} state_t;

  state_t             state;
  logic [GID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   remaining;
  logic [WIDTH-1:0]   cur_mask;

  logic [CW-1:0]      cand;
  logic               found;
  logic [GID_W-1:0]   sel_id;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   sel_cnt;
  logic               idx_ok;
  logic [GID_W-1:0]   rr_next;

  // Grant the first valid requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    req_ready = '0;
    sel_id    = '0;
    found     = 1'b0;
    cand      = '0;
    if (state == IDLE && reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + CW'(k);
        if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
        if (!found && req_valid[cand[GID_W-1:0]]) begin
          found  = 1'b1;
          sel_id = cand[GID_W-1:0];
        end
      end
      if (found) req_ready = N_REQ'(1) << sel_id;
    end
  end

  always_comb begin
    sel_idx = req_idx[int'(sel_id) * IDX_W +: IDX_W];
    sel_cnt = req_cnt[int'(sel_id) * CNT_W +: CNT_W];
    idx_ok  = int'(sel_idx) < WIDTH;
    rr_next = (sel_id == GID_W'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
  end

  // Sequencer: out-of-range or zero-count requests complete immediately without toggling
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      remaining <= '0;
      cur_mask  <= '0;
      q         <= '0;
      busy      <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= sel_id;
            rr_ptr   <= rr_next;
            cur_mask <= WIDTH'(1) << sel_idx;
            if (!idx_ok) begin
              done <= N_REQ'(1) << sel_id;
              err  <= 1'b1;
            end else if (sel_cnt == '0) begin
              done <= N_REQ'(1) << sel_id;
            end else begin
              remaining <= sel_cnt;
              busy      <= 1'b1;
              state     <= TOGGLE;
            end
          end
        end
        TOGGLE: begin
          if (!pause) begin
            q         <= q ^ cur_mask;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= N_REQ'(1) << grant_id;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Testbench for tff_toggle_arbiter: directed scenarios then randomized transactions
// checked against a transaction-level model (round-robin pointer plus toggle parity).
module tb_tff_toggle_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_idx;
  logic [15:0] req_cnt;
  logic [3:0]  req_ready;
  logic        pause;
  logic [7:0]  q;
  logic        busy;
  logic [1:0]  grant_id;
  logic [3:0]  done;
  logic        err;

  int          n_checks = 0;
  int          n_pass = 0;
  int          ptr = 0;
  logic [7:0]  exp_q = '0;

  // Index field widened to 4 bits so out-of-range indices (>= WIDTH) are reachable
  tff_toggle_arbiter #(.N_REQ(4), .WIDTH(8), .IDX_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_idx(req_idx),
    .req_cnt(req_cnt), .req_ready(req_ready), .pause(pause), .q(q),
    .busy(busy), .grant_id(grant_id), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One request set presented at a negedge; model predicts grant, toggle parity and done timing
  task automatic apply_stimulus(input logic [3:0] mask, input logic [15:0] idx_pk,
                                input logic [15:0] cnt_pk, input logic [31:0] pause_pat);
    int r, idx, cnt, left, cyc;
    logic [3:0] oh;
    logic [7:0] bitm;
    req_valid = mask;
    req_idx   = idx_pk;
    req_cnt   = cnt_pk;
    pause     = 1'($urandom_range(0, 1));
    r = -1;
    for (int k = 0; k < 4; k++)
      if (r < 0 && mask[(ptr + k) % 4]) r = (ptr + k) % 4;
    #1;
    if (r < 0) begin
      check_output("ready_none", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = '0;
      return;
    end
    oh = 4'(1 << r);
    check_output("ready_grant", 32'(req_ready), 32'(oh));
    idx = int'(idx_pk[r*4 +: 4]);
    cnt = int'(cnt_pk[r*4 +: 4]);
    ptr = (r + 1) % 4;
    @(negedge clk);
    check_output("grant_id", 32'(grant_id), 32'(r));
    if (idx >= 8 || cnt == 0) begin
      req_valid = '0;
      check_output("imm_done", 32'(done), 32'(oh));
      check_output("imm_err", 32'(err), (idx >= 8) ? 32'd1 : 32'd0);
      check_output("imm_busy", 32'(busy), 32'd0);
      check_output("imm_q", 32'(q), 32'(exp_q));
    end else begin
      bitm = 8'(1 << idx);
      left = cnt;
      cyc  = 0;
      req_valid = mask & ~oh;
      while (left > 0) begin
        pause = (cyc < 32) ? pause_pat[cyc] : 1'b0;
        check_output("tog_busy", 32'(busy), 32'd1);
        check_output("tog_done", 32'(done), 32'd0);
        check_output("tog_ready", 32'(req_ready), 32'd0);
        check_output("tog_q", 32'(q), 32'(exp_q ^ ((((cnt - left) % 2) == 1) ? bitm : 8'h00)));
        @(posedge clk);
        if (!pause) left--;
        cyc++;
        @(negedge clk);
      end
      exp_q = exp_q ^ (((cnt % 2) == 1) ? bitm : 8'h00);
      check_output("end_done", 32'(done), 32'(oh));
      check_output("end_err", 32'(err), 32'd0);
      check_output("end_busy", 32'(busy), 32'd0);
      check_output("end_q", 32'(q), 32'(exp_q));
      req_valid = '0;
      pause = 1'b0;
    end
    @(negedge clk);
    check_output("done_pulse", 32'(done), 32'd0);
    check_output("err_pulse", 32'(err), 32'd0);
  endtask

  initial begin
    logic [3:0]  mask;
    logic [15:0] ip, cp;
    reset = 1'b0;
    req_valid = '0;
    req_idx = '0;
    req_cnt = '0;
    pause = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_q", 32'(q), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_gid", 32'(grant_id), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single request r1 idx=2 cnt=3");
    apply_stimulus(4'b0010, 16'h0020, 16'h0030, 32'd0);

    $display("[TB] reset with q[2] set");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst2_q", 32'(q), 32'd0);
    check_output("rst2_ready", 32'(req_ready), 32'd0);
    check_output("rst2_done", 32'(done), 32'd0);
    reset = 1'b1;
    exp_q = '0;
    ptr = 0;
    @(negedge clk);

    $display("[TB] round-robin, all four valid");
    repeat (5) apply_stimulus(4'hF, 16'h3210, 16'h1111, 32'd0);

    $display("[TB] pause during toggle");
    apply_stimulus(4'b0001, 16'h0000, 16'h0002, 32'h0000_000E);

    $display("[TB] boundaries: cnt=0 and idx=9");
    apply_stimulus(4'b1000, 16'h1000, 16'h0000, 32'd0);
    apply_stimulus(4'b0001, 16'h0009, 16'h0003, 32'd0);

    $display("[TB] reset mid-transaction");
    req_valid = 4'b0100;
    req_idx = 16'h0500;
    req_cnt = 16'h0F00;
    pause = 1'b0;
    #1;
    check_output("mid_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    check_output("mid_busy", 32'(busy), 32'd1);
    check_output("mid_q", 32'(q), 32'(exp_q));
    reset = 1'b0;
    @(negedge clk);
    check_output("mid_rst_q", 32'(q), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q = '0;
    ptr = 0;
    repeat (3) begin
      @(negedge clk);
      check_output("mid_no_done", 32'(done), 32'd0);
    end
    apply_stimulus(4'hF, 16'h7654, 16'h1111, 32'd0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        ip[k*4 +: 4] = 4'($urandom_range(0, 9));
        cp[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      end
      apply_stimulus(mask, ip, cp, $urandom & $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
